// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared sizes and state encoding for the round-robin mux arbiter
package mux_rr_arbiter_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;
endpackage

// File: rtl/mux_rr_arbiter_mux4to1.sv
// mux4to1: plain 4:1 single-bit mux cell, a is the select msb, b the lsb
module mux4to1 (
  input  logic d0,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic a,
  input  logic b,
  output logic y
);
  // select one of four data bits
  always_comb y = a ? (b ? d3 : d2) : (b ? d1 : d0);
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter with bounded hold time owning a shared 4:1 mux
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       en,
  output logic       y
);
  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, owner_mask, cand;
  logic [SEL_W-1:0]   sel_q, sel_d, last_q, last_d, win_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_q, en_d, win_found, owner_req, hold_done, mux_y;
  // owner status; the owner is excluded from the search so a hold expiry hands over to someone else
  always_comb begin
    owner_req  = state_q == OWN && req[sel_q];
    hold_done  = cnt_q >= CNT_W'(MAX_HOLD);
    owner_mask = state_q == OWN ? NUM_REQ'(1) << sel_q : '0;
    cand       = req & ~owner_mask;
  end
  // rotating-priority search starting just after the last owner; nearest candidate is assigned last and wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ; k > 0; k--) begin
      if (cand[last_q + SEL_W'(k)]) begin
        win_found = 1'b1;
        win_idx   = last_q + SEL_W'(k);
      end
    end
  end
  // next state: keep the owner while it requests and its hold is not forcing a handover, else regrant or go idle
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (owner_req && !(hold_done && win_found)) begin
      cnt_d = hold_done ? CNT_W'(1) : cnt_q + CNT_W'(1);
    end else if (win_found) begin
      state_d = OWN;
      gnt_d   = NUM_REQ'(1) << win_idx;
      sel_d   = win_idx;
      en_d    = 1'b1;
      cnt_d   = CNT_W'(1);
      last_d  = win_idx;
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
      en_d    = 1'b0;
      cnt_d   = '0;
    end
  end
  // state and registered outputs; reset leaves last at 3 so requester 0 is first in line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
  mux4to1 u_mux (
    .d0(d[0]),
    .d1(d[1]),
    .d2(d[2]),
    .d3(d[3]),
    .a (sel_q[1]),
    .b (sel_q[0]),
    .y (mux_y)
  );
  assign gnt = gnt_q;
  assign sel = sel_q;
  assign en  = en_q;
  assign y   = mux_y & en_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed vector table, corner sequences and randomized invariant checks
module tb_mux_rr_arbiter;
  localparam int MAX_HOLD = 4;
  localparam int WAIT_MAX = 3 * MAX_HOLD + 1;
  logic       clk = 1'b0;
  logic       rst, en, y;
  logic [3:0] req, d, gnt;
  logic [1:0] sel;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .d  (d),
    .gnt(gnt),
    .sel(sel),
    .en (en),
    .y  (y)
  );
  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en;
    logic       y;
  } vec_t;
  vec_t vecs[12];
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] dd);
    rst = r;
    req = rq;
    d   = dd;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s, input logic e, input logic yy);
    chk({tag, " gnt"}, gnt, g);
    chk({tag, " sel"}, 4'(sel), 4'(s));
    chk({tag, " en"}, 4'(en), 4'(e));
    chk({tag, " y"}, 4'(y), 4'(yy));
  endtask
  initial begin
    logic [3:0] rq, prev_gnt;
    logic [1:0] own;
    int         wt[4];
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'b1011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'b1001, 4'b0111, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 4'b1001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    rst = 1'b1;
    req = '0;
    d   = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].rst, vecs[i].req, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].en, vecs[i].y);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'b0100, 4'b0000);
      chk($sformatf("solo hold %0d gnt", i), gnt, 4'b0100);
    end
    cyc(1'b0, 4'b0101, 4'b0001);
    chk("solo rollover keep gnt", gnt, 4'b0100);
    cyc(1'b0, 4'b0101, 4'b0001);
    chk_all("solo rollover handover", 4'b0001, 2'd0, 1'b1, 1'b1);
    cyc(1'b0, 4'b0010, 4'b0000);
    chk_all("pre-reset owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(1'b1, 4'b1111, 4'b1111);
    chk_all("mid-own reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(1'b0, 4'b1111, 4'b1111);
    chk_all("post-reset grant", 4'b0001, 2'd0, 1'b1, 1'b1);
    cyc(1'b1, 4'b0000, 4'b1010);
    for (int k = 0; k < 21; k++) begin
      own = 2'((k / MAX_HOLD) % 4);
      cyc(1'b0, 4'b1111, 4'b1010);
      chk_all($sformatf("all-req cyc%0d", k), 4'b0001 << own, own, 1'b1, own[0]);
    end
    cyc(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4; i++) wt[i] = 0;
    prev_gnt = '0;
    for (int k = 0; k < 10000; k++) begin
      rq = 4'($urandom) | 4'($urandom);
      cyc(1'b0, rq, 4'($urandom));
      chk("rand onehot0", 4'($onehot0(gnt)), 4'd1);
      chk("rand en", 4'(en), 4'(|gnt));
      if (en) chk("rand gnt/sel", gnt, 4'b0001 << sel);
      chk("rand y", 4'(y), 4'(en & d[sel]));
      if (gnt != 4'b0000 && gnt != prev_gnt) chk("rand legit grant", 4'(|(gnt & rq)), 4'd1);
      for (int i = 0; i < 4; i++) begin
        wt[i] = (rq[i] && !gnt[i]) ? wt[i] + 1 : 0;
        chk($sformatf("rand wait%0d", i), 4'(wt[i] <= WAIT_MAX), 4'd1);
      end
      prev_gnt = gnt;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
